// File: rtl/universal_gate_bist_ctrl.sv
// BIST sequencer for the NAND/NOR universal gate unit: sweeps all four a/b vectors,
// checks both outputs, reports fail_map/pass. Optional `UG_BIST_SIGNATURE_EN adds an 8-bit MISR signature.
module universal_gate_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_out1,
  input  logic       gate_out2,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_map
`ifdef UG_BIST_SIGNATURE_EN
  ,
  output logic [7:0] signature
`endif
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [3:0] LAST_PASS = 4'(NUM_PASSES - 1);
  // Expected {nor,nand} indexed by vector number
  localparam logic [3:0][1:0] EXP_TBL = {2'b00, 2'b01, 2'b01, 2'b11};

  state_t     state, state_nxt;
  logic [1:0] vec;
  logic [3:0] pass_cnt;
  logic [3:0] settle_cnt;
  logic [1:0] exp_val;
  logic [7:0] miss;
  logic       last_vec;
  logic [1:0] vec_nxt;

  always_comb begin
    exp_val  = EXP_TBL[vec];
    miss     = 8'h00;
    miss[{1'b0, vec}] = gate_out1 ^ exp_val[0];
    miss[{1'b1, vec}] = gate_out2 ^ exp_val[1];
    last_vec = (vec == 2'd3) && (pass_cnt == LAST_PASS);
    vec_nxt  = vec + 2'd1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = (SETTLE_LD == 4'd0) ? SAMPLE : SETTLE;
      SETTLE:  if (settle_cnt <= 4'd1) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= 2'd0;
      pass_cnt   <= 4'd0;
      settle_cnt <= 4'd0;
      gate_a     <= 1'b0;
      gate_b     <= 1'b0;
      pass       <= 1'b0;
      fail_map   <= 8'h00;
    end else begin
      case (state)
        IDLE: if (start) begin
          vec      <= 2'd0;
          pass_cnt <= 4'd0;
          gate_a   <= 1'b0;
          gate_b   <= 1'b0;
          pass     <= 1'b0;
          fail_map <= 8'h00;
        end
        DRIVE:  settle_cnt <= SETTLE_LD;
        SETTLE: settle_cnt <= settle_cnt - 4'd1;
        SAMPLE: begin
          fail_map <= fail_map | miss;
          if (last_vec) begin
            pass <= ((fail_map | miss) == 8'h00);
          end else begin
            // 2-bit vec wraps 3->0 on its own at the end of a sweep
            vec    <= vec_nxt;
            gate_a <= vec_nxt[0];
            gate_b <= vec_nxt[1];
            if (vec == 2'd3) pass_cnt <= pass_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UG_BIST_SIGNATURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signature <= 8'h00;
    end else if (state == IDLE && start) begin
      signature <= 8'hFF;
    end else if (state == SAMPLE) begin
      signature <= {signature[6:0], signature[7] ^ signature[5] ^ signature[4] ^ signature[3]}
                   ^ {6'b0, gate_out2, gate_out1};
    end
  end
`endif

endmodule

// File: tb/tb_universal_gate_bist_ctrl.sv
// Directed bench: two BIST instances (defaults; SETTLE_CYCLES=0/NUM_PASSES=2) driving
// behavioural gate models with selectable faults.
module tb_universal_gate_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // fault modes: 0 good, 1 NAND stuck-1, 2 NOR stuck-0, 3 outputs swapped
  logic [1:0] fm0 = 2'd0, fm1 = 2'd0;
  logic start0 = 1'b0, start1 = 1'b0;

  logic a0, b0, o1_0, o2_0, busy0, done0, pass0;
  logic a1, b1, o1_1, o2_1, busy1, done1, pass1;
  logic [7:0] fmap0, fmap1;
`ifdef UG_BIST_SIGNATURE_EN
  logic [7:0] sig0, sig1;
`endif

  assign o1_0 = (fm0 == 2'd1) ? 1'b1 : (fm0 == 2'd3) ? ~(a0 | b0) : ~(a0 & b0);
  assign o2_0 = (fm0 == 2'd2) ? 1'b0 : (fm0 == 2'd3) ? ~(a0 & b0) : ~(a0 | b0);
  assign o1_1 = (fm1 == 2'd1) ? 1'b1 : (fm1 == 2'd3) ? ~(a1 | b1) : ~(a1 & b1);
  assign o2_1 = (fm1 == 2'd2) ? 1'b0 : (fm1 == 2'd3) ? ~(a1 & b1) : ~(a1 | b1);

  universal_gate_bist_ctrl u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .gate_out1(o1_0), .gate_out2(o2_0),
    .gate_a(a0), .gate_b(b0), .busy(busy0), .done(done0), .pass(pass0), .fail_map(fmap0)
`ifdef UG_BIST_SIGNATURE_EN
    , .signature(sig0)
`endif
  );

  universal_gate_bist_ctrl #(.SETTLE_CYCLES(0), .NUM_PASSES(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_out1(o1_1), .gate_out2(o2_1),
    .gate_a(a1), .gate_b(b1), .busy(busy1), .done(done1), .pass(pass1), .fail_map(fmap1)
`ifdef UG_BIST_SIGNATURE_EN
    , .signature(sig1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One run on dut0; done expected 16 edges after the start edge (4 vectors x 4 cycles).
  // start is held for 'hold' extra edges to show it is ignored while busy.
  task automatic run0(input string tag, input int hold, input logic [7:0] exp_fm, input logic exp_pass);
    @(negedge clk) start0 = 1'b1;
    @(posedge clk); #1;
    if (hold == 0) start0 = 1'b0;
    chk({tag, ".busy_rise"}, busy0, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (i == hold) start0 = 1'b0;
      if (i == 15) begin
        chk({tag, ".done_early"}, done0, 1'b0);
        chk({tag, ".busy_late"}, busy0, 1'b1);
      end
      if (i == 16) begin
        chk({tag, ".done"}, done0, 1'b1);
        chk({tag, ".busy_fall"}, busy0, 1'b0);
        chk({tag, ".fail_map"}, fmap0, exp_fm);
        chk({tag, ".pass"}, pass0, exp_pass);
      end
      if (i == 17) begin
        chk({tag, ".done_pulse"}, done0, 1'b0);
        chk({tag, ".pass_hold"}, pass0, exp_pass);
      end
    end
  endtask

  initial begin
    int n_done, first_at, second_at, overlap, rst_done;
    n_done = 0; first_at = -1; second_at = -1; overlap = 0; rst_done = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.gate_a", a0, 1'b0);
    chk("rst.gate_b", b0, 1'b0);
    chk("rst.busy", busy0, 1'b0);
    chk("rst.done", done0, 1'b0);
    chk("rst.pass", pass0, 1'b0);
    chk("rst.fail_map", fmap0, 8'h00);
`ifdef UG_BIST_SIGNATURE_EN
    chk("rst.signature", sig0, 8'h00);
`endif
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);

    // fault-free, start held 3 extra edges (ignored while busy)
    fm0 = 2'd0;
    run0("good", 3, 8'h00, 1'b1);
`ifdef UG_BIST_SIGNATURE_EN
    chk("good.signature", sig0, 8'hEF);
`endif
    chk("good.hold_a", a0, 1'b1);
    chk("good.hold_b", b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("good.no_restart", busy0, 1'b0);

    fm0 = 2'd1; run0("nand_sa1", 0, 8'h08, 1'b0);
    fm0 = 2'd2; run0("nor_sa0", 0, 8'h10, 1'b0);
    fm0 = 2'd3; run0("swap", 0, 8'h66, 1'b0);

    // back-to-back on dut1 (SETTLE 0, 2 passes): done 16 edges after start, restart right after
    fm1 = 2'd0;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 35; i++) begin
      @(posedge clk); #1;
      if (done1) begin
        n_done++;
        if (first_at < 0) first_at = i; else second_at = i;
        chk("b2b.pass", pass1, 1'b1);
        chk("b2b.fail_map", fmap1, 8'h00);
      end
      if (done1 && busy1) overlap++;
    end
    start1 = 1'b0;
    chk("b2b.n_done", n_done, 2);
    chk("b2b.first_done", first_at, 16);
    chk("b2b.second_done", second_at, 34);
    chk("b2b.no_overlap", overlap, 0);
    repeat (3) @(posedge clk); #1;
    chk("b2b.idle", busy1, 1'b0);

    // reset during SETTLE of vector 2 on dut0
    fm0 = 2'd0;
    @(negedge clk) start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid.vec2_a", a0, 1'b0);
    chk("mid.vec2_b", b0, 1'b1);
    chk("mid.busy", busy0, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid.rst_busy", busy0, 1'b0);
    chk("mid.rst_b", b0, 1'b0);
    chk("mid.rst_fail_map", fmap0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done0) rst_done++;
    end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done0) rst_done++;
    end
    chk("mid.no_done", rst_done, 0);
    chk("mid.idle", busy0, 1'b0);
    run0("after_rst", 0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
